mii_mac_tx: RTL and testbench

Transmit-side RMII MAC for the engineer-station link. Builds one Ethernet II frame per start request: preamble, SFD, destination MAC, source MAC, type 0x008A, and a fixed-length application payload fetched from an external byte buffer. Frames go out on the 2-bit RMII transmit interface at 50 MHz. Output frames are accepted unchanged by the matching receive MAC (type 0x008A, 139-byte payload at buffer addresses 0..138).

---
 rtl/mii_mac_tx_if.sv | 23 ++
 rtl/mii_mac_tx.sv | 180 ++++++++++++++++++
 tb/tb_mii_mac_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mii_mac_tx_if.sv
// Frame request, payload buffer and RMII transmit signals of mii_mac_tx.
// master = MAC side, slave = the logic that feeds it and takes the line.
interface mii_mac_tx_if;
  logic        i_start;
  logic [47:0] im_dmac_addr;
  logic [47:0] im_smac_addr;
  logic [10:0] o_rdaddr;
  logic [7:0]  im_rddata;
  logic        o_txen;
  logic [1:0]  om_txdata;
  logic        o_busy;
  logic        o_done;

  modport master (
    input  i_start, im_dmac_addr, im_smac_addr, im_rddata,
    output o_rdaddr, o_txen, om_txdata, o_busy, o_done
  );

  modport slave (
    output i_start, im_dmac_addr, im_smac_addr, im_rddata,
    input  o_rdaddr, o_txen, om_txdata, o_busy, o_done
  );
endinterface

// File: rtl/mii_mac_tx.sv
// RMII transmit MAC: one Ethernet II frame per start, 2 bits per clock, LSB dibit first.
// Define MII_MAC_TX_FCS_EN to append a CRC-32 FCS after the payload.
module mii_mac_tx #(
  parameter logic [15:0] TYPE_PROTOCOL = 16'h008A,
  parameter logic [10:0] ALDATA_NUM    = 11'd138,
  parameter logic [7:0]  IFG_CYCLES    = 8'd48
) (
  input  logic         i_clk,
  input  logic         i_rst,
  mii_mac_tx_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, SFD, DMAC, SMAC, TYPE, AL_DATA,
`ifdef MII_MAC_TX_FCS_EN
    FCS,
`endif
    IFG
  } state_t;

  state_t      st, nst;
  logic [1:0]  dcnt;
  logic [2:0]  bcnt, nbcnt;
  logic [10:0] pcnt, npcnt;
  logic [7:0]  icnt;
  logic [5:0]  sh;
  logic [7:0]  nbyte;
  logic [47:0] dmac_q, smac_q;
  logic        txen, busy, done;
  logic [1:0]  txdata;
  logic [10:0] rdaddr;
  logic        go;

  // A new frame may also start straight out of the last IFG clock, so a held
  // start gives exactly IFG_CYCLES idle clocks between frames.
  assign go = bus.i_start && (st == IDLE || (st == IFG && icnt == IFG_CYCLES - 8'd1));

`ifdef MII_MAC_TX_FCS_EN
  logic [31:0] crc, crc_nx, fcs;

  function automatic logic [31:0] crc2(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++)
      r = (r[0] ^ d[i]) ? ({1'b0, r[31:1]} ^ 32'hEDB88320) : {1'b0, r[31:1]};
    return r;
  endfunction

  // The dibit on the line this clock is folded in, so the first FCS byte
  // (loaded on the final payload edge) already covers the last payload dibit.
  always_comb begin
    crc_nx = crc;
    if (st inside {DMAC, SMAC, TYPE, AL_DATA}) crc_nx = crc2(crc, txdata);
    fcs = ~crc_nx;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)          crc <= '1;
    else if (st == SFD) crc <= '1;
    else                crc <= crc_nx;
  end
`endif

  // Next field position and the byte that will fill it at the slot boundary.
  always_comb begin
    nst   = st;
    nbcnt = bcnt + 3'd1;
    npcnt = pcnt;
    nbyte = 8'h00;
    case (st)
      PREAMBLE: if (bcnt == 3'd6) begin nst = SFD; nbcnt = 3'd0; end
      SFD:      begin nst = DMAC; nbcnt = 3'd0; end
      DMAC:     if (bcnt == 3'd5) begin nst = SMAC; nbcnt = 3'd0; end
      SMAC:     if (bcnt == 3'd5) begin nst = TYPE; nbcnt = 3'd0; end
      TYPE:     if (bcnt == 3'd1) begin nst = AL_DATA; npcnt = 11'd0; end
      AL_DATA: begin
        npcnt = pcnt + 11'd1;
        nbcnt = 3'd0;
        if (pcnt == ALDATA_NUM) begin
`ifdef MII_MAC_TX_FCS_EN
          nst = FCS;
`else
          nst = IFG;
`endif
        end
      end
`ifdef MII_MAC_TX_FCS_EN
      FCS:      if (bcnt == 3'd3) nst = IFG;
`endif
      default: ;
    endcase
    case (nst)
      PREAMBLE: nbyte = 8'h55;
      SFD:      nbyte = 8'hD5;
      DMAC:     nbyte = dmac_q[8*(5-int'(nbcnt)) +: 8];
      SMAC:     nbyte = smac_q[8*(5-int'(nbcnt)) +: 8];
      TYPE:     nbyte = nbcnt[0] ? TYPE_PROTOCOL[7:0] : TYPE_PROTOCOL[15:8];
      AL_DATA:  nbyte = bus.im_rddata;
`ifdef MII_MAC_TX_FCS_EN
      FCS:      nbyte = fcs[8*int'(nbcnt[1:0]) +: 8];
`endif
      default:  nbyte = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st     <= IDLE;
      dcnt   <= 2'd0;
      bcnt   <= 3'd0;
      pcnt   <= 11'd0;
      icnt   <= 8'd0;
      sh     <= 6'd0;
      dmac_q <= 48'd0;
      smac_q <= 48'd0;
      txen   <= 1'b0;
      txdata <= 2'b00;
      rdaddr <= 11'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        st     <= PREAMBLE;
        dcnt   <= 2'd0;
        bcnt   <= 3'd0;
        pcnt   <= 11'd0;
        dmac_q <= bus.im_dmac_addr;
        smac_q <= bus.im_smac_addr;
        txen   <= 1'b1;
        txdata <= 2'b01;
        sh     <= 6'h15;
        rdaddr <= 11'd0;
        busy   <= 1'b1;
      end else begin
        case (st)
          IDLE: rdaddr <= 11'd0;
          IFG: begin
            icnt <= icnt + 8'd1;
            if (icnt == IFG_CYCLES - 8'd2) done <= 1'b1;
            if (icnt == IFG_CYCLES - 8'd1) begin
              st     <= IDLE;
              busy   <= 1'b0;
              rdaddr <= 11'd0;
            end
          end
          default: begin
            if (dcnt != 2'd3) begin
              dcnt   <= dcnt + 2'd1;
              txdata <= sh[1:0];
              sh     <= {2'b00, sh[5:2]};
            end else begin
              dcnt <= 2'd0;
              st   <= nst;
              bcnt <= nbcnt;
              pcnt <= npcnt;
              if (nst == IFG) begin
                txen   <= 1'b0;
                txdata <= 2'b00;
                icnt   <= 8'd0;
              end else begin
                txdata <= nbyte[1:0];
                sh     <= nbyte[7:2];
              end
              // Fetch for the next payload slot starts as this one starts.
              if (nst == AL_DATA && npcnt != ALDATA_NUM) rdaddr <= npcnt + 11'd1;
            end
          end
        endcase
      end
    end
  end

  assign bus.o_txen    = txen;
  assign bus.om_txdata = txdata;
  assign bus.o_rdaddr  = rdaddr;
  assign bus.o_busy    = busy;
  assign bus.o_done    = done;

endmodule

// File: tb/tb_mii_mac_tx.sv
// Directed bench for mii_mac_tx: frame content, fetch timing, start filtering,
// back-to-back frames and mid-frame reset; FCS residue when MII_MAC_TX_FCS_EN.
module tb_mii_mac_tx;
  localparam logic [47:0] DMAC = 48'hFFFF_FFFF_FF01;
  localparam logic [47:0] SMAC = 48'h0200_0000_0005;
`ifdef MII_MAC_TX_FCS_EN
  localparam int NBYTES = 165;
`else
  localparam int NBYTES = 161;
`endif
  localparam int NCLK   = NBYTES * 4;
  localparam int PERIOD = NCLK + 48;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  mii_mac_tx_if bus();

  mii_mac_tx dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  always #10 i_clk = ~i_clk;

  // Payload buffer: buffer[k] = k, one clock read latency.
  always @(posedge i_clk) bus.im_rddata <= bus.o_rdaddr[7:0];

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [7:0] rx [0:255];

  function automatic logic [7:0] exp_byte(input int i);
    if (i < 7)   return 8'h55;
    if (i == 7)  return 8'hD5;
    if (i < 14)  return DMAC[8*(13-i) +: 8];
    if (i < 20)  return SMAC[8*(19-i) +: 8];
    if (i == 20) return 8'h00;
    if (i == 21) return 8'h8A;
    return 8'(i - 22);
  endfunction

  task automatic test_reset();
    bus.i_start = 1'b0;
    bus.im_dmac_addr = DMAC;
    bus.im_smac_addr = SMAC;
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    total++; if (bus.o_txen !== 1'b0) begin bad++; $display("FAIL reset_txen got=%b want=0", bus.o_txen); end
    total++; if (bus.om_txdata !== 2'b00) begin bad++; $display("FAIL reset_txdata got=%b want=00", bus.om_txdata); end
    total++; if (bus.o_rdaddr !== 11'd0) begin bad++; $display("FAIL reset_rdaddr got=%0d want=0", bus.o_rdaddr); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.o_busy); end
    total++; if (bus.o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.o_done); end
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    total++; if (bus.o_txen !== 1'b0) begin bad++; $display("FAIL idle_txen got=%b want=0", bus.o_txen); end
  endtask

  task automatic test_frame();
    int s, n, berr, rerr, first, exp_a, dk;
    logic [7:0] b;
    logic [31:0] c;
    bus.i_start = 1'b1;
    s = cyc;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    total++; if (bus.o_txen !== 1'b1 || bus.om_txdata !== 2'b01 || bus.o_busy !== 1'b1) begin
      bad++; $display("FAIL first_dibit got txen=%b txd=%b busy=%b want 1/01/1", bus.o_txen, bus.om_txdata, bus.o_busy);
    end
    n = 0; rerr = 0;
    while (bus.o_txen === 1'b1 && n < 1000) begin
      b = rx[n/4];
      b[2*(n%4) +: 2] = bus.om_txdata;
      rx[n/4] = b;
      exp_a = (n < 84) ? 0 : ((n/4 - 21) > 138 ? 138 : n/4 - 21);
      if (bus.o_rdaddr !== 11'(exp_a)) rerr++;
      n++;
      @(negedge i_clk);
    end
    total++; if (n !== NCLK) begin bad++; $display("FAIL txen_len got=%0d want=%0d", n, NCLK); end
    total++; if (bus.om_txdata !== 2'b00) begin bad++; $display("FAIL ifg_txdata got=%b want=00", bus.om_txdata); end
    total++; if (rerr !== 0) begin bad++; $display("FAIL rdaddr_walk got=%0d bad clocks want=0", rerr); end
    berr = 0; first = -1;
    for (int i = 0; i < 161; i++)
      if (rx[i] !== exp_byte(i)) begin berr++; if (first < 0) first = i; end
    total++; if (berr !== 0) begin
      bad++; $display("FAIL frame_bytes got=%0d bad bytes (first at %0d: %h, want %h) want=0",
                      berr, first, rx[first], exp_byte(first));
    end
`ifdef MII_MAC_TX_FCS_EN
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < 165; i++)
      for (int k = 0; k < 8; k++)
        c = (c[0] ^ rx[i][k]) ? ({1'b0, c[31:1]} ^ 32'hEDB88320) : {1'b0, c[31:1]};
    total++; if (c !== 32'hDEBB20E3) begin bad++; $display("FAIL fcs_residue got=%h want=debb20e3", c); end
`else
    c = 32'd0;
`endif
    dk = -1;
    for (int w = 0; w < 200 && dk < 0; w++) begin
      if (bus.o_done === 1'b1) dk = cyc - s;
      else @(negedge i_clk);
    end
    total++; if (dk !== PERIOD) begin bad++; $display("FAIL done_time got=%0d want=%0d", dk, PERIOD); end
    @(negedge i_clk);
    total++; if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      bad++; $display("FAIL after_done got busy=%b done=%b want 0/0", bus.o_busy, bus.o_done);
    end
  endtask

  task automatic test_ignore_start();
    int ntx, nd, dk;
    ntx = 0; nd = 0; dk = -1;
    bus.i_start = 1'b1;
    for (int k = 1; k <= PERIOD + 100; k++) begin
      @(negedge i_clk);
      if (bus.o_txen === 1'b1) ntx++;
      if (bus.o_done === 1'b1) begin nd++; dk = k; end
      bus.i_start = (k == 300) || (k == NCLK + 15);
    end
    bus.i_start = 1'b0;
    total++; if (ntx !== NCLK) begin bad++; $display("FAIL ignore_txen got=%0d want=%0d", ntx, NCLK); end
    total++; if (nd !== 1) begin bad++; $display("FAIL ignore_done_cnt got=%0d want=1", nd); end
    total++; if (dk !== PERIOD) begin bad++; $display("FAIL ignore_done_time got=%0d want=%0d", dk, PERIOD); end
  endtask

  task automatic test_back_to_back();
    int fall1, rise2, nd, d1, d2;
    logic prev, busy_mid;
    fall1 = -1; rise2 = -1; nd = 0; d1 = -1; d2 = -1; prev = 1'b0; busy_mid = 1'b0;
    bus.i_start = 1'b1;
    for (int k = 1; k <= 2 * PERIOD + 20; k++) begin
      @(negedge i_clk);
      if (prev === 1'b1 && bus.o_txen === 1'b0 && fall1 < 0) fall1 = k;
      if (prev === 1'b0 && bus.o_txen === 1'b1 && k > 1 && rise2 < 0) rise2 = k;
      if (bus.o_done === 1'b1) begin nd++; if (d1 < 0) d1 = k; else d2 = k; end
      if (k == PERIOD) busy_mid = bus.o_busy;
      prev = bus.o_txen;
      if (k == PERIOD + 10) bus.i_start = 1'b0;
    end
    total++; if (fall1 !== NCLK + 1) begin bad++; $display("FAIL b2b_fall got=%0d want=%0d", fall1, NCLK + 1); end
    total++; if (rise2 - fall1 !== 48) begin bad++; $display("FAIL b2b_gap got=%0d want=48", rise2 - fall1); end
    total++; if (nd !== 2) begin bad++; $display("FAIL b2b_done_cnt got=%0d want=2", nd); end
    total++; if (d1 !== PERIOD) begin bad++; $display("FAIL b2b_done1 got=%0d want=%0d", d1, PERIOD); end
    total++; if (d2 !== 2 * PERIOD) begin bad++; $display("FAIL b2b_done2 got=%0d want=%0d", d2, 2 * PERIOD); end
    total++; if (busy_mid !== 1'b1) begin bad++; $display("FAIL b2b_busy_mid got=%b want=1", busy_mid); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%b want=0", bus.o_busy); end
  endtask

  task automatic test_reset_mid();
    int ntx, nd;
    ntx = 0; nd = 0;
    bus.i_start = 1'b1;
    for (int k = 1; k <= PERIOD + 50; k++) begin
      @(negedge i_clk);
      bus.i_start = 1'b0;
      if (k == 301) begin
        total++; if (bus.o_txen !== 1'b0) begin bad++; $display("FAIL rstmid_txen got=%b want=0", bus.o_txen); end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.o_busy); end
        total++; if (bus.om_txdata !== 2'b00) begin bad++; $display("FAIL rstmid_txdata got=%b want=00", bus.om_txdata); end
        i_rst = 1'b0;
      end
      if (k > 301 && bus.o_txen === 1'b1) ntx++;
      if (bus.o_done === 1'b1) nd++;
      if (k == 300) i_rst = 1'b1;
    end
    total++; if (nd !== 0) begin bad++; $display("FAIL rstmid_done got=%0d want=0", nd); end
    total++; if (ntx !== 0) begin bad++; $display("FAIL rstmid_txen_after got=%0d want=0", ntx); end
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.im_dmac_addr = DMAC;
    bus.im_smac_addr = SMAC;
    test_reset();
    test_frame();
    repeat (5) @(negedge i_clk);
    test_ignore_start();
    repeat (5) @(negedge i_clk);
    test_back_to_back();
    repeat (5) @(negedge i_clk);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
